// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, XLEN+1 cycle fixed latency
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rd_val
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              neg_a;
  logic              neg_b;
  logic [2*XLEN-1:0] prod;

  logic              in_neg_a;
  logic              in_neg_b;
  logic [XLEN-1:0]   in_a_mag;
  logic [XLEN-1:0]   in_b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] prod_next;
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   a_orig;
  logic [XLEN-1:0]   result;

  always_comb begin
    in_neg_a = rs1_val[XLEN-1] && ((funct3 == 3'b001) || (funct3 == 3'b010) ||
                                   (funct3 == 3'b100) || (funct3 == 3'b110));
    in_neg_b = rs2_val[XLEN-1] && ((funct3 == 3'b001) || (funct3 == 3'b100) ||
                                   (funct3 == 3'b110));
    in_a_mag = in_neg_a ? -rs1_val : rs1_val;
    in_b_mag = in_neg_b ? -rs2_val : rs2_val;
  end

  // Multiply keeps the multiplier in prod's low half; divide keeps the dividend there
  // and shifts quotient bits in behind it while the partial remainder grows in the high half.
  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a_mag} : '0);
    div_shift = prod[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, b_mag};
    if (op[2]) begin
      prod_next = div_diff[XLEN] ? {div_shift[XLEN-1:0], prod[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};
    end else begin
      prod_next = {mul_sum, prod[XLEN-1:1]};
    end
  end

  always_comb begin
    prod_fixed = (neg_a ^ neg_b) ? -prod : prod;
    quot       = prod[XLEN-1:0];
    rem        = prod[2*XLEN-1:XLEN];
    a_orig     = neg_a ? -a_mag : a_mag;
    if (!op[2]) begin
      result = (op[1:0] == 2'b00) ? prod_fixed[XLEN-1:0] : prod_fixed[2*XLEN-1:XLEN];
    end else if (b_mag == '0) begin
      result = op[1] ? a_orig : '1;
    end else if (op[1]) begin
      result = neg_a ? -rem : rem;
    end else begin
      result = (neg_a ^ neg_b) ? -quot : quot;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      prod   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      rd_val <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state <= CALC;
            busy  <= 1'b1;
            cnt   <= '0;
            op    <= funct3;
            a_mag <= in_a_mag;
            b_mag <= in_b_mag;
            neg_a <= in_neg_a;
            neg_b <= in_neg_b;
            prod  <= {{XLEN{1'b0}}, (funct3[2] ? in_a_mag : in_b_mag)};
          end
        end
        CALC: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            prod <= prod_next;
            cnt  <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN - 1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!abort) begin
            done   <= 1'b1;
            rd_val <= result;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [2:0]      funct3 = '0;
  logic [XLEN-1:0] rs1_val = '0;
  logic [XLEN-1:0] rs2_val = '0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] rd_val;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .abort(abort),
    .busy(busy), .done(done), .rd_val(rd_val)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int          req_seq = 0, req_seen = 0, kill_seq = 0, kill_seen = 0;
  logic [2:0]  req_f = '0;
  logic [31:0] req_a = '0, req_b = '0;
  bit          pend_valid = 0;
  int          pend_done = 0;
  logic [31:0] pend_res = '0;
  logic [31:0] rd_model = '0;
  bit          exp_busy, exp_done;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Timeline model: an accepted op completes exactly XLEN+1 edges after its accept edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst) begin
      pend_valid = 0;
      rd_model   = '0;
    end else begin
      if (kill_seq != kill_seen) begin
        kill_seen  = kill_seq;
        pend_valid = 0;
      end
      if (req_seq != req_seen) begin
        req_seen   = req_seq;
        pend_valid = 1;
        pend_done  = cyc + XLEN + 1;
        pend_res   = model(req_f, req_a, req_b);
      end
    end
    exp_busy = pend_valid && (cyc < pend_done);
    exp_done = pend_valid && (cyc == pend_done);
    if (exp_done) begin
      rd_model   = pend_res;
      pend_valid = 0;
    end
    check("busy", 32'(busy), 32'(exp_busy));
    check("done", 32'(done), 32'(exp_done));
    check("rd_val", rd_val, rd_model);
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    funct3  = f;
    rs1_val = a;
    rs2_val = b;
    start   = 1'b1;
    req_f   = f;
    req_a   = a;
    req_b   = b;
    req_seq++;
    @(negedge clk);
    start   = 1'b0;
    funct3  = 3'($urandom);
    rs1_val = $urandom;
    rs2_val = $urandom;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (pend_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (pend_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done timeout at cycle %0d", cyc);
    end
  endtask

  task automatic run_lit(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lit);
    issue(f, a, b);
    wait_done();
    check("literal", rd_val, lit);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [2:0]  lf [12];
  logic [31:0] la [12];
  logic [31:0] lb [12];
  logic [31:0] lr [12];

  initial begin
    int k, bc;
    lf = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6, 3'd6};
    la = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100,
           32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFF9};
    lb = '{32'h80000000, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2, 32'd7,
           32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    lr = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14,
           32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'hFFFFFFF9};

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    issue(3'd0, 32'd7, 32'hFFFFFFFD);
    k  = 0;
    bc = 0;
    while (!done && k < 100) begin
      if (busy) bc++;
      @(negedge clk);
      k++;
    end
    check("mul_lit", rd_val, 32'hFFFFFFEB);
    check("busy_cycles", 32'(bc), 32'd33);
    check("done_latency", 32'(k), 32'd33);

    for (int i = 0; i < 12; i++) run_lit(lf[i], la[i], lb[i], lr[i]);

    issue(3'd0, 32'h1234, 32'h5678);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    kill_seq++;
    @(negedge clk);
    abort = 1'b0;
    check("abort_hold", rd_val, 32'hFFFFFFF9);
    run_lit(3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF);

    issue(3'd4, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    start   = 1'b1;
    funct3  = 3'd0;
    rs1_val = 32'd9;
    rs2_val = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("busy_start_ignored", rd_val, 32'd14);

    start  = 1'b1;
    abort  = 1'b1;
    funct3 = 3'd0;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);

    issue(3'd0, 32'hDEAD, 32'hBEEF);
    repeat (19) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_val", rd_val, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_lit(3'd0, 32'd3, 32'd4, 32'd12);

    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(3'($urandom_range(0, 7)), pick(), pick());
      wait_done();
    end
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide execution unit implementing the RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at a parametrised data width. It sits beside the single-cycle ALU in the execute stage. Control decode hands it R-type instructions with opcode 0110011 and funct7 0000001, selected by funct3. Results take a fixed number of cycles, so the control FSM stalls on `busy` and writes `rd_val` back on `done`.

## Interface
- `XLEN`, default 32: operand and result width; must be even and ≥ 4.
- `CNT_W`, default $clog2(XLEN)+1: iteration counter width; derived, do not override.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `funct3`  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1_val`  in  XLEN  operand A (multiplicand / dividend)
- `rs2_val`  in  XLEN  operand B (multiplier / divisor)
- `abort`  in  1  kill the in-flight operation (pipeline flush)
- `busy`  out  1  high in CALC and FIX
- `done`  out  1  one-cycle pulse; `rd_val` is valid in that cycle
- `rd_val`  out  XLEN  result; held until the next `done`

## Operation
- States:
  - IDLE → CALC on `start`.
  - CALC runs exactly XLEN iterations, then → FIX.
  - FIX → IDLE, asserting `done`.
- On accept, the unit latches `funct3` plus the operand magnitudes and signs. Later changes on the inputs have no effect.
- Sign handling:
  - MULH and DIV/REM: both operands are signed.
  - MULHSU: A is signed, B is unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Operate on absolute values and record the negate flags.
- Multiply: shift-add, one multiplier bit per iteration, into a 2·XLEN product register.
  - MUL returns product[XLEN-1:0].
  - MULH, MULHSU, MULHU return product[2·XLEN-1:XLEN].
  - In FIX, negate the full 2·XLEN product when the operand signs differ (signed cases only).
- Divide: restoring division, one quotient bit per iteration.
  - In FIX, the quotient is negated if the signs differ; the remainder takes the sign of the dividend.
- Divide by zero:
  - DIV/DIVU return all-ones.
  - REM/REMU return `rs1_val` unchanged.
- Signed overflow (A = most-negative, B = −1):
  - DIV returns the most-negative value.
  - REM returns 0.
- Special cases still take the full fixed latency. The result is substituted in FIX.
- `abort`:
  - In CALC or FIX: → IDLE next edge, no `done`, `rd_val` unchanged.
  - In IDLE: ignored, and it has priority over a simultaneous `start`.
- `start` while busy is ignored. The upstream stage must hold the request until it observes `busy` low.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `rd_val`=0, and all internal registers 0.
- Latency: `start` is sampled at edge 0, so `busy`=1 from edge 0. Iterations run on edges 1..XLEN. At edge XLEN+1, `rd_val` is loaded and `done`=1 for one cycle; `busy` is 0 from that same edge.
- Total latency is XLEN+1 cycles from accept to `done` (33 for XLEN=32).
- Back-to-back: `start` asserted in the cycle where `done`=1 is accepted. Throughput is one op per XLEN+1 cycles.
- Reset asserted mid-operation clears everything immediately and asynchronously. No `done` is produced.
- The iteration counter wraps only via reset to 0 on accept. No other wrap-around is permitted.

## Test plan
- MUL 7 × 0xFFFFFFFD → `rd_val`=0xFFFFFFEB. `done` must pulse exactly 33 cycles after accept, and `busy` must be high for 33 cycles.
- Signedness of the high half:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Signed divide:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM of the same operands → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
- Corner cases:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
  - Each must take 33 cycles.
- Control edge cases:
  - `abort` at iteration 10 → no `done`, `rd_val` keeps the previous value, and a new `start` the next cycle completes normally.
  - `start` while busy with different operands → ignored.
- `rst` low at iteration 20 → all outputs 0 immediately with no clock edge needed. After release, MUL 3×4 → 12 with normal latency.
